pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch/execute sequencer.
// Walks instruction memory from address 0, presents each fetched word to the
// control unit for a single EXEC cycle, and stops on the END opcode or on a
// halt request. A halt request made during a fetch discards that fetch.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter logic [6:0]  END_OPCODE = 7'h7F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [14:0]         mem_data,
    output logic [6:0]          opcode,
    output logic [7:0]          lit,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         retired_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [14:0]         r_ir;
    logic                r_halt_pend;
    logic [15:0]         r_retired;

    logic                w_start_ok;
    logic                w_is_end;
    logic                w_discard;
    logic                w_load;

    // Saturating increment for the retired-instruction counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Qualify start, END detection and the fetch outcome for this cycle.
    always_comb begin
        w_start_ok = 1'b0;
        w_is_end   = 1'b0;
        w_discard  = 1'b0;
        w_load     = 1'b0;
        w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
        w_is_end   = (mem_data[14:8] == END_OPCODE);
        if ((r_state == ST_FETCH) && mem_ack) begin
            // A halt seen during this fetch (earlier or now) wins over the data.
            w_discard = r_halt_pend || halt_req;
            w_load    = !w_discard && !w_is_end;
        end else begin
            w_discard = 1'b0;
            w_load    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!mem_ack) begin
                    w_next_state = ST_FETCH;
                end else if (w_load) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (halt_req) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (w_start_ok) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_HALT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Program counter, instruction register, halt-pending flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= {PC_WIDTH{1'b0}};
            r_ir        <= {END_OPCODE, 8'h00};
            r_halt_pend <= 1'b0;
            r_retired   <= 16'h0000;
        end else begin
            if (w_start_ok) begin
                r_pc      <= {PC_WIDTH{1'b0}};
                r_retired <= 16'h0000;
            end else if (w_load) begin
                r_ir <= mem_data;
                r_pc <= r_pc + PC_WIDTH'(1);
            end else if (r_state == ST_EXEC) begin
                r_retired <= sat_inc16(r_retired);
            end else begin
                r_pc <= r_pc;
            end

            if (w_next_state == ST_HALT) begin
                r_halt_pend <= 1'b0;
            end else if ((r_state == ST_FETCH) && halt_req) begin
                r_halt_pend <= 1'b1;
            end else begin
                r_halt_pend <= r_halt_pend;
            end
        end
    end

    // Output decode from the state and the registered datapath.
    always_comb begin
        mem_req     = (r_state == ST_FETCH);
        instr_valid = (r_state == ST_EXEC);
        busy        = (r_state == ST_FETCH) || (r_state == ST_EXEC);
        halted      = (r_state == ST_HALT);
        mem_addr    = r_pc;
        pc          = r_pc;
        opcode      = r_ir[14:8];
        lit         = r_ir[7:0];
        retired_cnt = r_retired;
    end

endmodule
